// File: rtl/card_draw_arbiter.sv
// Card draw arbiter: grants player/dealer card requests, sequences one deck draw per grant,
// and tracks remaining cards, reshuffles and deck timeouts.
module card_draw_arbiter #(
  parameter int unsigned CARD_W    = 4,
  parameter int unsigned DECK_SIZE = 52,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [1:0]        i_turn,
  input  logic              i_player_req,
  input  logic              i_dealer_req,
  output logic              o_deck_draw,
  input  logic              i_deck_valid,
  input  logic [CARD_W-1:0] i_deck_card,
  output logic              o_player_ack,
  output logic              o_dealer_ack,
  output logic [CARD_W-1:0] o_card,
  output logic [5:0]        o_cards_remaining,
  output logic              o_reshuffle_req,
  input  logic              i_reshuffle_done,
  output logic              o_busy,
  output logic              o_error
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned REM_W = 6;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DRAW      = 3'd1,
    S_WAIT      = 3'd2,
    S_DELIVER   = 3'd3,
    S_RESHUFFLE = 3'd4,
    S_ERROR     = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic               grant_dealer_q, grant_dealer_d;
  logic               last_dealer_q, last_dealer_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic [CARD_W-1:0]  card_q, card_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic               draw_q, draw_d;
  logic               pack_q, pack_d;
  logic               dack_q, dack_d;
  logic               reshuf_q, reshuf_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               p_elig, d_elig, pick_dealer;

  // Turn filter: 01 restricts to player, 10 to dealer, 00/11 let both compete.
  assign p_elig      = i_player_req && (i_turn != 2'b10);
  assign d_elig      = i_dealer_req && (i_turn != 2'b01);
  assign pick_dealer = d_elig && (!p_elig || !last_dealer_q);
  assign cnt_inc     = cnt_q + CNT_W'(1);

  // Next-state and datapath update
  always_comb begin
    state_d        = state_q;
    grant_dealer_d = grant_dealer_q;
    last_dealer_d  = last_dealer_q;
    cnt_d          = cnt_q;
    card_d         = card_q;
    rem_d          = rem_q;

    unique case (state_q)
      S_IDLE: begin
        if (rem_q == REM_W'(0)) begin
          state_d = S_RESHUFFLE;
        end else if (p_elig || d_elig) begin
          grant_dealer_d = pick_dealer;
          last_dealer_d  = pick_dealer;
          state_d        = S_DRAW;
        end
      end
      S_DRAW: begin
        cnt_d   = CNT_W'(0);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_deck_valid) begin
          card_d  = i_deck_card;
          if (rem_q != REM_W'(0)) begin
            rem_d = rem_q - REM_W'(1);
          end
          state_d = S_DELIVER;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CNT_W'(TIMEOUT)) begin
            state_d = S_ERROR;
          end
        end
      end
      S_DELIVER: begin
        state_d = S_IDLE;
      end
      S_RESHUFFLE: begin
        if (i_reshuffle_done) begin
          rem_d   = REM_W'(DECK_SIZE);
          state_d = S_IDLE;
        end
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_comb begin
    draw_d   = (state_d == S_DRAW);
    pack_d   = (state_d == S_DELIVER) && !grant_dealer_d;
    dack_d   = (state_d == S_DELIVER) && grant_dealer_d;
    reshuf_d = (state_d == S_RESHUFFLE);
    busy_d   = (state_d != S_IDLE) && (state_d != S_ERROR);
    err_d    = (state_d == S_ERROR);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q        <= S_IDLE;
      grant_dealer_q <= 1'b0;
      last_dealer_q  <= 1'b0;
      cnt_q          <= CNT_W'(0);
      card_q         <= CARD_W'(0);
      rem_q          <= REM_W'(DECK_SIZE);
      draw_q         <= 1'b0;
      pack_q         <= 1'b0;
      dack_q         <= 1'b0;
      reshuf_q       <= 1'b0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_dealer_q <= grant_dealer_d;
      last_dealer_q  <= last_dealer_d;
      cnt_q          <= cnt_d;
      card_q         <= card_d;
      rem_q          <= rem_d;
      draw_q         <= draw_d;
      pack_q         <= pack_d;
      dack_q         <= dack_d;
      reshuf_q       <= reshuf_d;
      busy_q         <= busy_d;
      err_q          <= err_d;
    end
  end

  assign o_deck_draw       = draw_q;
  assign o_player_ack      = pack_q;
  assign o_dealer_ack      = dack_q;
  assign o_card            = card_q;
  assign o_cards_remaining = rem_q;
  assign o_reshuffle_req   = reshuf_q;
  assign o_busy            = busy_q;
  assign o_error           = err_q;

endmodule

// File: tb/tb_card_draw_arbiter.sv
// Self-checking bench for card_draw_arbiter: arbitration table, directed corner cases,
// and a randomized run against a transaction-level model.
module tb_card_draw_arbiter;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b1;
  logic [1:0] i_turn = 2'b00;
  logic       i_player_req = 1'b0;
  logic       i_dealer_req = 1'b0;
  logic       o_deck_draw;
  logic       i_deck_valid = 1'b0;
  logic [3:0] i_deck_card = 4'd0;
  logic       o_player_ack;
  logic       o_dealer_ack;
  logic [3:0] o_card;
  logic [5:0] o_cards_remaining;
  logic       o_reshuffle_req;
  logic       i_reshuffle_done = 1'b0;
  logic       o_busy;
  logic       o_error;

  int checks = 0;
  int errors = 0;

  card_draw_arbiter #(.CARD_W(4), .DECK_SIZE(52), .TIMEOUT(15)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_turn(i_turn),
    .i_player_req(i_player_req), .i_dealer_req(i_dealer_req),
    .o_deck_draw(o_deck_draw), .i_deck_valid(i_deck_valid), .i_deck_card(i_deck_card),
    .o_player_ack(o_player_ack), .o_dealer_ack(o_dealer_ack), .o_card(o_card),
    .o_cards_remaining(o_cards_remaining), .o_reshuffle_req(o_reshuffle_req),
    .i_reshuffle_done(i_reshuffle_done), .o_busy(o_busy), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_player_ack && o_dealer_ack) begin
      errors++;
      $display("FAIL both_acks at %0t: player_ack=1 dealer_ack=1, required at most one", $time);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_reset_n = 1'b0; i_turn = 2'b00; i_player_req = 1'b0; i_dealer_req = 1'b0;
    i_deck_valid = 1'b0; i_reshuffle_done = 1'b0;
    @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  // One transaction from IDLE at exact minimum latency; requests are dropped after the grant.
  task automatic do_txn(input logic [1:0] turn, input logic p, input logic d, input logic [3:0] card,
                        input logic ep, input logic ed, input int exp_rem);
    i_turn = turn; i_player_req = p; i_dealer_req = d;
    @(negedge i_clk);
    i_player_req = 1'b0; i_dealer_req = 1'b0;
    check("txn_draw", o_deck_draw, ep | ed);
    check("txn_busy", o_busy, ep | ed);
    if (ep | ed) begin
      @(negedge i_clk);
      i_deck_valid = 1'b1; i_deck_card = card;
      check("txn_draw_one_cycle", o_deck_draw, 0);
      @(negedge i_clk);
      i_deck_valid = 1'b0;
      check("txn_player_ack", o_player_ack, ep);
      check("txn_dealer_ack", o_dealer_ack, ed);
      check("txn_card", o_card, card);
      check("txn_remaining", o_cards_remaining, exp_rem);
      @(negedge i_clk);
      check("txn_ack_drop", o_player_ack | o_dealer_ack, 0);
      check("txn_idle_busy", o_busy, 0);
    end
  endtask

  typedef struct {
    logic [1:0] turn;
    logic       preq;
    logic       dreq;
    logic [3:0] card;
    logic       exp_p;
    logic       exp_d;
  } vec_t;

  vec_t vecs[8];

  // Reference model state
  int   m_rem;
  logic m_last_dealer;

  initial begin
    logic [1:0] rt;
    logic rp, rd, ep, ed, win_dealer, got;
    logic [3:0] rcard;
    int dly;

    vecs[0] = '{2'b00, 1'b1, 1'b0, 4'd3,  1'b1, 1'b0};
    vecs[1] = '{2'b00, 1'b0, 1'b1, 4'd7,  1'b0, 1'b1};
    vecs[2] = '{2'b00, 1'b1, 1'b1, 4'd12, 1'b0, 1'b1};
    vecs[3] = '{2'b01, 1'b1, 1'b1, 4'd1,  1'b1, 1'b0};
    vecs[4] = '{2'b10, 1'b1, 1'b1, 4'd15, 1'b0, 1'b1};
    vecs[5] = '{2'b11, 1'b1, 1'b1, 4'd5,  1'b0, 1'b1};
    vecs[6] = '{2'b01, 1'b0, 1'b1, 4'd2,  1'b0, 1'b0};
    vecs[7] = '{2'b10, 1'b1, 1'b0, 4'd8,  1'b0, 1'b0};

    // Reset state
    do_reset();
    check("rst_remaining", o_cards_remaining, 52);
    check("rst_card", o_card, 0);
    check("rst_outputs", {o_deck_draw, o_player_ack, o_dealer_ack, o_reshuffle_req, o_busy, o_error}, 0);

    // Arbitration table, each vector from a fresh reset
    for (int i = 0; i < 8; i++) begin
      do_reset();
      do_txn(vecs[i].turn, vecs[i].preq, vecs[i].dreq, vecs[i].card, vecs[i].exp_p, vecs[i].exp_d,
             (vecs[i].exp_p | vecs[i].exp_d) ? 51 : 52);
    end

    // Basic player draw with card 9
    do_reset();
    do_txn(2'b01, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0, 51);

    // Both held through two transactions: dealer first, then player
    do_reset();
    i_turn = 2'b00; i_player_req = 1'b1; i_dealer_req = 1'b1;
    @(negedge i_clk); check("rr_draw1", o_deck_draw, 1);
    @(negedge i_clk); i_deck_valid = 1'b1; i_deck_card = 4'd10;
    @(negedge i_clk); i_deck_valid = 1'b0;
    check("rr_first_dealer", {o_player_ack, o_dealer_ack}, 2'b01);
    @(negedge i_clk); check("rr_idle_gap", o_deck_draw, 0);
    @(negedge i_clk); check("rr_draw2", o_deck_draw, 1);
    i_player_req = 1'b0; i_dealer_req = 1'b0;
    @(negedge i_clk); i_deck_valid = 1'b1; i_deck_card = 4'd11;
    @(negedge i_clk); i_deck_valid = 1'b0;
    check("rr_second_player", {o_player_ack, o_dealer_ack}, 2'b10);
    check("rr_card2", o_card, 11);
    check("rr_remaining", o_cards_remaining, 50);

    // Valid on the last WAIT cycle still wins over timeout
    do_reset();
    i_turn = 2'b00; i_player_req = 1'b1;
    @(negedge i_clk); i_player_req = 1'b0;
    @(negedge i_clk);
    repeat (14) @(negedge i_clk);
    i_deck_valid = 1'b1; i_deck_card = 4'd6;
    @(negedge i_clk); i_deck_valid = 1'b0;
    check("late_valid_ack", o_player_ack, 1);
    check("late_valid_no_err", o_error, 0);

    // Timeout: 15 WAIT cycles then sticky error, only reset clears it
    do_reset();
    i_turn = 2'b10; i_dealer_req = 1'b1;
    @(negedge i_clk); i_dealer_req = 1'b0;
    check("to_draw", o_deck_draw, 1);
    for (int k = 0; k < 15; k++) begin
      @(negedge i_clk);
      check("to_wait_no_err", {o_busy, o_error}, 2'b10);
    end
    @(negedge i_clk);
    check("to_error", {o_busy, o_error}, 2'b01);
    i_deck_valid = 1'b1; i_dealer_req = 1'b1;
    @(negedge i_clk);
    i_deck_valid = 1'b0;
    check("to_err_no_ack", {o_player_ack, o_dealer_ack, o_deck_draw}, 0);
    @(negedge i_clk);
    check("to_err_sticky", o_error, 1);
    do_reset();
    check("to_reset_clear", {o_error, o_busy}, 0);
    check("to_reset_rem", o_cards_remaining, 52);

    // Reset in WAIT abandons the transaction
    i_turn = 2'b01; i_player_req = 1'b1;
    @(negedge i_clk); i_player_req = 1'b0;
    @(negedge i_clk); i_reset_n = 1'b0;
    @(negedge i_clk); i_reset_n = 1'b1;
    check("wrst_idle", {o_busy, o_player_ack, o_dealer_ack, o_deck_draw}, 0);
    check("wrst_rem", o_cards_remaining, 52);
    i_deck_valid = 1'b1;
    @(negedge i_clk); i_deck_valid = 1'b0;
    check("wrst_no_ack", o_player_ack | o_dealer_ack, 0);

    // Deck exhaustion and reshuffle
    do_reset();
    for (int k = 0; k < 52; k++) do_txn(2'b01, 1'b1, 1'b0, 4'(k), 1'b1, 1'b0, 51 - k);
    check("ex_empty", o_cards_remaining, 0);
    i_turn = 2'b01; i_player_req = 1'b1;
    @(negedge i_clk);
    check("ex_reshuffle_req", o_reshuffle_req, 1);
    check("ex_no_draw", o_deck_draw, 0);
    @(negedge i_clk);
    check("ex_reshuffle_hold", {o_reshuffle_req, o_deck_draw}, 2'b10);
    i_reshuffle_done = 1'b1;
    @(negedge i_clk); i_reshuffle_done = 1'b0;
    check("ex_reloaded", o_cards_remaining, 52);
    check("ex_req_drop", o_reshuffle_req, 0);
    @(negedge i_clk); i_player_req = 1'b0;
    check("ex_served_draw", o_deck_draw, 1);
    @(negedge i_clk); i_deck_valid = 1'b1; i_deck_card = 4'd13;
    @(negedge i_clk); i_deck_valid = 1'b0;
    check("ex_served_ack", o_player_ack, 1);
    check("ex_served_rem", o_cards_remaining, 51);

    // Randomized transactions against the model
    do_reset();
    m_rem = 52; m_last_dealer = 1'b0;
    for (int t = 0; t < 130; t++) begin
      do begin
        rt = 2'($urandom_range(0, 3));
        rp = 1'($urandom_range(0, 1));
        rd = 1'($urandom_range(0, 1));
        ep = rp && (rt != 2'b10);
        ed = rd && (rt != 2'b01);
      end while (!(ep || ed));
      win_dealer = (ep && ed) ? !m_last_dealer : ed;
      i_turn = rt; i_player_req = rp; i_dealer_req = rd;

      if (m_rem == 0) begin
        got = 1'b0;
        for (int k = 0; k < 3 && !got; k++) begin
          @(negedge i_clk);
          if (o_reshuffle_req) got = 1'b1;
          check("rnd_no_draw_empty", o_deck_draw, 0);
        end
        check("rnd_reshuffle_seen", got, 1);
        repeat ($urandom_range(0, 3)) @(negedge i_clk);
        i_reshuffle_done = 1'b1;
        @(negedge i_clk); i_reshuffle_done = 1'b0;
        m_rem = 52;
        check("rnd_reload", o_cards_remaining, m_rem);
      end

      got = 1'b0;
      for (int k = 0; k < 4 && !got; k++) begin
        @(negedge i_clk);
        if (o_deck_draw) got = 1'b1;
      end
      check("rnd_draw_seen", got, 1);

      // Inputs change after grant and stray strobes outside their states must be ignored
      i_turn = 2'($urandom_range(0, 3));
      i_player_req = 1'($urandom_range(0, 1));
      i_dealer_req = 1'($urandom_range(0, 1));
      i_deck_valid = 1'($urandom_range(0, 1));
      i_deck_card = 4'($urandom_range(0, 15));
      i_reshuffle_done = 1'($urandom_range(0, 1));
      @(negedge i_clk);
      i_deck_valid = 1'b0; i_reshuffle_done = 1'b0;
      dly = int'($urandom_range(0, 4));
      repeat (dly) @(negedge i_clk);
      rcard = 4'($urandom_range(0, 15));
      i_deck_valid = 1'b1; i_deck_card = rcard;
      @(negedge i_clk);
      i_deck_valid = 1'b0;
      m_rem = m_rem - 1;
      m_last_dealer = win_dealer;
      check("rnd_player_ack", o_player_ack, !win_dealer);
      check("rnd_dealer_ack", o_dealer_ack, win_dealer);
      check("rnd_card", o_card, rcard);
      check("rnd_remaining", o_cards_remaining, m_rem);
    end
    i_player_req = 1'b0; i_dealer_req = 1'b0;
    @(negedge i_clk);
    check("rnd_end_no_err", o_error, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/card_draw_arbiter.md
CARD_DRAW_ARBITER -- requirements
Module: card_draw_arbiter

Interface
REQ-001 SHALL have parameter CARD_W, default 4, card code width.
REQ-002 SHALL have parameter DECK_SIZE, default 52, cards per full deck.
REQ-003 SHALL have parameter TIMEOUT, default 15, max WAIT cycles before fault.
REQ-004 SHALL have port i_clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port i_reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port i_turn  input  2  turn code: 00 none, 01 player, 10 dealer, 11 treated as none.
REQ-007 SHALL have port i_player_req  input  1  player hand requests one card, level, held until ack.
REQ-008 SHALL have port i_dealer_req  input  1  dealer hand requests one card, level, held until ack.
REQ-009 SHALL have port o_deck_draw  output  1  one-cycle draw strobe to card deck.
REQ-010 SHALL have port i_deck_valid  input  1  deck card valid, sampled only in WAIT.
REQ-011 SHALL have port i_deck_card  input  CARD_W  card code from deck.
REQ-012 SHALL have port o_player_ack  output  1  one-cycle delivery pulse to player hand.
REQ-013 SHALL have port o_dealer_ack  output  1  one-cycle delivery pulse to dealer hand.
REQ-014 SHALL have port o_card  output  CARD_W  delivered card, valid while an ack is high.
REQ-015 SHALL have port o_cards_remaining  output  6  undealt cards in current deck.
REQ-016 SHALL have port o_reshuffle_req  output  1  level request to deck to reshuffle.
REQ-017 SHALL have port i_reshuffle_done  input  1  one-cycle reshuffle completion from deck.
REQ-018 SHALL have port o_busy  output  1  high in every state except IDLE and ERROR.
REQ-019 SHALL have port o_error  output  1  sticky deck-timeout fault.

Function
REQ-020 SHALL implement Moore FSM states IDLE, DRAW, WAIT, DELIVER, RESHUFFLE, ERROR; all outputs decoded from registered state.
REQ-021 IDLE: if o_cards_remaining==0 SHALL go RESHUFFLE (takes precedence over requests); else if an eligible request exists SHALL latch grant and go DRAW; else stay.
REQ-022 Eligibility: i_turn=01 only player eligible; i_turn=10 only dealer eligible; i_turn none both eligible, round-robin.
REQ-023 Round-robin SHALL grant the requester not granted last; last-grant register updates on every grant; after reset dealer wins first tie.
REQ-024 DRAW: o_deck_draw=1 for exactly this cycle; unconditionally go WAIT next cycle.
REQ-025 WAIT: on i_deck_valid=1 SHALL capture i_deck_card, decrement o_cards_remaining, go DELIVER; timeout counter increments each WAIT cycle without valid.
REQ-026 WAIT: when the counter reaches TIMEOUT without valid SHALL go ERROR; valid in the same cycle wins over timeout.
REQ-027 DELIVER: o_player_ack or o_dealer_ack (per latched grant) =1 for this cycle only with o_card held; unconditionally go IDLE next.
REQ-028 Minimum latency: request seen in IDLE at cycle n -> o_deck_draw at n+1 -> valid at n+2 -> ack at n+3.
REQ-029 Request deassert or i_turn change after grant SHALL NOT cancel the transaction; card still delivered to latched requester.
REQ-030 Requests SHALL be ignored outside IDLE; request still high in the IDLE after DELIVER counts as a new request.
REQ-031 i_deck_valid outside WAIT and i_reshuffle_done outside RESHUFFLE SHALL be ignored.
REQ-032 RESHUFFLE: o_reshuffle_req=1; on i_reshuffle_done SHALL load o_cards_remaining=DECK_SIZE and go IDLE.
REQ-033 ERROR: o_error=1, no strobes or acks; exit only via reset.
REQ-034 o_player_ack and o_dealer_ack SHALL never be high in the same cycle.
REQ-035 o_cards_remaining SHALL never wrap below 0; decrement occurs only in WAIT->DELIVER.

Reset
REQ-036 On i_reset_n=0 at a clock edge SHALL enter IDLE from any state, abandoning any transaction without ack.
REQ-037 Reset values: o_cards_remaining=DECK_SIZE, o_card=0, timeout counter 0, last grant=player, all 1-bit outputs 0.

Verification
REQ-038 i_turn=01, player req at cycle 0, valid+card 4'd9 at cycle 2 -> draw at 1, o_player_ack and o_card=9 at 3, remaining 51.
REQ-039 i_turn=00, both req held for two transactions -> first ack to dealer, second ack to player.
REQ-040 Valid never asserted in WAIT -> o_error=1 after 15 WAIT cycles, no ack; reset clears to IDLE, remaining=52.
REQ-041 52 deliveries then req -> o_reshuffle_req=1, no draw; i_reshuffle_done -> remaining=52, request then served.
REQ-042 i_reset_n=0 during WAIT -> IDLE next cycle, no ack, remaining=52, o_busy=0.
